// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-precision add/sub over WORDS x N bits using one shared N-bit CLA, LSW first.
module carry_lookahead_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g, p;
  logic [N:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  // 4-bit lookahead groups; group carries ripple between groups
  for (genvar k = 0; k < N / 4; k++) begin : grp
    localparam int L = 4 * k;
    assign c[L+1] = g[L] | (p[L] & c[L]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & c[L]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & c[L]);
    assign c[L+4] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                  | (p[L+3] & p[L+2] & p[L+1] & g[L]) | ((&p[L+3:L]) & c[L]);
  end
  assign sum = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

module wide_add_sequencer #(
  parameter int N = 32,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [N*WORDS-1:0]   A,
  input  logic [N*WORDS-1:0]   B,
  input  logic                 sub,
  input  logic                 cin,
  output logic [N*WORDS-1:0]   result,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 busy
);
  localparam int W = N * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, zacc, cout, last;
  logic [N-1:0] a_w, b_w, sum;
  assign a_w = a_r[idx*N +: N];
  assign b_w = b_r[idx*N +: N];
  assign last = idx == IW'(WORDS - 1);
  assign start_ready = state == IDLE;
  assign busy = state != IDLE;
  carry_lookahead_adder #(.N(N)) u_cla (.a(a_w), .b(b_w), .cin(carry), .sum(sum), .cout(cout));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      zacc <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_r <= A;
          b_r <= sub ? ~B : B;
          carry <= cin;
          idx <= '0;
          zacc <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          result[idx*N +: N] <= sum;
          carry <= cout;
          zacc <= zacc && sum == '0;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            flag_n <= sum[N-1];
            flag_z <= zacc && sum == '0;
            flag_c <= cout;
            flag_v <= (a_w[N-1] == b_w[N-1]) && (sum[N-1] != a_w[N-1]);
            done_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (done_ready) begin
          done_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed checks of the wide add/sub sequencer (WORDS=4 and WORDS=1).
module tb_wide_add_sequencer;
  logic clk = 0, reset = 1;
  logic start_valid = 0, sub = 0, cin = 0, done_ready = 1;
  logic [127:0] A = 0, B = 0;
  logic start_ready, flag_n, flag_z, flag_c, flag_v, done_valid, busy;
  logic [127:0] result;
  logic sv1 = 0, sub1 = 0, cin1 = 0;
  logic [31:0] a1 = 0, b1 = 0, res1;
  logic sr1, fn1, fz1, fc1, fv1, dv1, busy1;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.N(32), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .sub(sub), .cin(cin), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy));

  wide_add_sequencer #(.N(32), .WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(sr1),
    .A(a1), .B(b1), .sub(sub1), .cin(cin1), .result(res1),
    .flag_n(fn1), .flag_z(fz1), .flag_c(fc1), .flag_v(fv1),
    .done_valid(dv1), .done_ready(1'b1), .busy(busy1));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept at edge t, expect done_valid only after edge t+4; scramble inputs after accept.
  task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                        input logic s, input logic c, input logic [127:0] exp, input logic [3:0] nzcv);
    A = a; B = b; sub = s; cin = c; start_valid = 1; done_ready = 1;
    step();
    start_valid = 0; A = ~a; B = ~b; sub = ~s; cin = ~c;
    check({tag, " busy"}, busy, 1);
    repeat (3) step();
    check({tag, " early"}, done_valid, 0);
    step();
    check({tag, " dv"}, done_valid, 1);
    check({tag, " res"}, result, exp);
    check({tag, " nzcv"}, {flag_n, flag_z, flag_c, flag_v}, nzcv);
    step();
    check({tag, " idle"}, start_ready, 1);
  endtask

  initial begin
    reset = 1;
    repeat (2) step();
    reset = 0;
    check("rst ready", start_ready, 1);
    check("rst busy", busy, 0);
    check("rst dv", done_valid, 0);
    check("rst res", result, 0);
    check("rst flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    check("rst1 ready", sr1, 1);

    run_op("ones+1", {128{1'b1}}, 128'd1, 0, 0, 128'd0, 4'b0110);
    run_op("0-1", 128'd0, 128'd1, 1, 1, {128{1'b1}}, 4'b1000);
    run_op("5-5", 128'd5, 128'd5, 1, 1, 128'd0, 4'b0110);
    run_op("maxpos+1", {1'b0, {127{1'b1}}}, 128'd1, 0, 0, {1'b1, 127'd0}, 4'b1001);
    run_op("minneg*2", {1'b1, 127'd0}, {1'b1, 127'd0}, 0, 0, 128'd0, 4'b0111);
    run_op("wordcarry", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 0, 0,
           128'h0000_0001_0000_0000_0000_0000_0000_0000, 4'b0000);
    run_op("sbc10-3", 128'd10, 128'd3, 1, 0, 128'd6, 4'b0010);

    // backpressure with a pending start held
    A = 128'd1; B = 128'd2; sub = 0; cin = 0; start_valid = 1; done_ready = 0;
    step();
    A = 128'd100; B = 128'd200;
    repeat (4) step();
    check("bp dv", done_valid, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp hold dv", done_valid, 1);
      check("bp hold res", result, 128'd3);
      check("bp hold flags", {flag_n, flag_z, flag_c, flag_v}, 0);
      check("bp no accept", start_ready, 0);
    end
    done_ready = 1;
    step();
    check("bp release dv", done_valid, 0);
    check("bp release ready", start_ready, 1);
    step();
    start_valid = 0;
    check("bp pend busy", busy, 1);
    repeat (3) step();
    check("bp pend early", done_valid, 0);
    step();
    check("bp pend dv", done_valid, 1);
    check("bp pend res", result, 128'd300);
    step();

    // reset during the second RUN cycle
    A = 128'd9; B = 128'd9; start_valid = 1;
    step();
    start_valid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    check("abort dv", done_valid, 0);
    check("abort ready", start_ready, 1);
    check("abort res", result, 0);
    check("abort busy", busy, 0);
    run_op("3+4", 128'd3, 128'd4, 0, 0, 128'd7, 4'b0000);

    // WORDS=1: RUN lasts a single cycle
    a1 = 32'hFFFF_FFFF; b1 = 32'd1; sv1 = 1;
    step();
    sv1 = 0; a1 = 0; b1 = 0;
    check("w1 busy", busy1, 1);
    check("w1 early", dv1, 0);
    step();
    check("w1 dv", dv1, 1);
    check("w1 res", res1, 0);
    check("w1 nzcv", {fn1, fz1, fc1, fv1}, 4'b0110);
    step();
    a1 = 32'h7FFF_FFFF; b1 = 32'd1; sv1 = 1;
    step();
    sv1 = 0;
    step();
    check("w1b dv", dv1, 1);
    check("w1b res", res1, 32'h8000_0000);
    check("w1b nzcv", {fn1, fz1, fc1, fv1}, 4'b1001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
